// File: rtl/beam_event_encoder_pkg.sv
// rtl/beam_event_encoder_pkg.sv - shared state type, defaults and transition rules for the beam event encoder
package beam_event_encoder_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_A1,
    ST_AB_IN,
    ST_B1_IN,
    ST_B1,
    ST_AB_OUT,
    ST_A1_OUT,
    ST_WAIT_CLR,
    ST_FAULT
  } state_t;

  localparam int DEBOUNCE_DEF = 2;
  localparam int TIMEOUT_DEF  = 16;

  function automatic int dwell_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int DWELL_W_DEF = dwell_width(TIMEOUT_DEF);

  // States in which the dwell timeout applies
  function automatic logic is_tracking(input state_t s);
    return !(s inside {ST_IDLE, ST_WAIT_CLR, ST_FAULT});
  endfunction

  // Pattern-driven next state; p = {beam_a, beam_b} after debouncing
  function automatic state_t next_state(input state_t s, input logic a, input logic b);
    logic [1:0] p;
    state_t     ns;
    p  = {a, b};
    ns = ST_WAIT_CLR;
    case (s)
      ST_IDLE:
        case (p)
          2'b00:   ns = ST_IDLE;
          2'b10:   ns = ST_A1;
          2'b01:   ns = ST_B1;
          default: ns = ST_WAIT_CLR;
        endcase
      ST_A1:
        case (p)
          2'b00:   ns = ST_IDLE;
          2'b10:   ns = ST_A1;
          2'b11:   ns = ST_AB_IN;
          default: ns = ST_WAIT_CLR;
        endcase
      ST_AB_IN:
        case (p)
          2'b11:   ns = ST_AB_IN;
          2'b10:   ns = ST_A1;
          2'b01:   ns = ST_B1_IN;
          default: ns = ST_WAIT_CLR;
        endcase
      ST_B1_IN:
        case (p)
          2'b01:   ns = ST_B1_IN;
          2'b11:   ns = ST_AB_IN;
          2'b00:   ns = ST_IDLE;
          default: ns = ST_WAIT_CLR;
        endcase
      ST_B1:
        case (p)
          2'b01:   ns = ST_B1;
          2'b00:   ns = ST_IDLE;
          2'b11:   ns = ST_AB_OUT;
          default: ns = ST_WAIT_CLR;
        endcase
      ST_AB_OUT:
        case (p)
          2'b11:   ns = ST_AB_OUT;
          2'b01:   ns = ST_B1;
          2'b10:   ns = ST_A1_OUT;
          default: ns = ST_WAIT_CLR;
        endcase
      ST_A1_OUT:
        case (p)
          2'b10:   ns = ST_A1_OUT;
          2'b11:   ns = ST_AB_OUT;
          2'b00:   ns = ST_IDLE;
          default: ns = ST_WAIT_CLR;
        endcase
      default:
        ns = (p == 2'b00) ? ST_IDLE : s;
    endcase
    return ns;
  endfunction

endpackage

// File: rtl/beam_debounce.sv
// rtl/beam_debounce.sv - two-flop synchronizer followed by a consecutive-sample debouncer for one beam
module beam_debounce
  import beam_event_encoder_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clock,
  input  logic clear,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // cnt holds how many consecutive samples so far disagree with level
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/beam_event_encoder.sv
// rtl/beam_event_encoder.sv - turns two debounced photo-beams into entry/exit pulses with dwell timeout fault
module beam_event_encoder
  import beam_event_encoder_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic clear,
  input  logic ent,
  input  logic beam_a,
  input  logic beam_b,
  output logic in,
  output logic out,
  output logic fault
);

  localparam int DW = dwell_width(TIMEOUT);
  localparam logic [DW-1:0] DWELL_LAST = DW'(TIMEOUT - 1);
  localparam logic [DW-1:0] DWELL_MAX  = DW'(TIMEOUT);

  logic          a;
  logic          b;
  state_t        state;
  state_t        state_nx;
  logic [DW-1:0] dwell;

  beam_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_a (
    .clock (clock),
    .clear (clear),
    .raw   (beam_a),
    .level (a)
  );

  beam_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_b (
    .clock (clock),
    .clear (clear),
    .raw   (beam_b),
    .level (b)
  );

  // Timeout takes priority over any pattern move on the same edge
  always_comb begin
    state_nx = next_state(state, a, b);
    if (is_tracking(state) && (dwell == DWELL_LAST)) begin
      state_nx = ST_FAULT;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= ST_IDLE;
      in    <= 1'b0;
      out   <= 1'b0;
      fault <= 1'b0;
      dwell <= '0;
    end else if (!ent) begin
      state <= ST_IDLE;
      in    <= 1'b0;
      out   <= 1'b0;
      fault <= 1'b0;
      dwell <= '0;
    end else begin
      state <= state_nx;
      in    <= (state == ST_B1_IN)  && (state_nx == ST_IDLE);
      out   <= (state == ST_A1_OUT) && (state_nx == ST_IDLE);
      fault <= (state_nx == ST_FAULT);
      if (state_nx != state) begin
        dwell <= '0;
      end else if (dwell != DWELL_MAX) begin
        dwell <= dwell + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_beam_event_encoder.sv
// tb/tb_beam_event_encoder.sv - randomized self-checking bench for beam_event_encoder against a path-walk model
module tb_beam_event_encoder;

  localparam int DEB = 2;
  localparam int TO  = 16;

  logic clock  = 1'b0;
  logic clear  = 1'b0;
  logic ent    = 1'b0;
  logic beam_a = 1'b0;
  logic beam_b = 1'b0;
  logic in;
  logic out;
  logic fault;

  int errors = 0;
  int checks = 0;
  int n_in   = 0;
  int n_out  = 0;

  always #5 clock = ~clock;

  beam_event_encoder #(.DEBOUNCE(DEB), .TIMEOUT(TO)) dut (
    .clock  (clock),
    .clear  (clear),
    .ent    (ent),
    .beam_a (beam_a),
    .beam_b (beam_b),
    .in     (in),
    .out    (out),
    .fault  (fault)
  );

  // Model: beams walk a path of patterns {a,b}; mode 0 = walking (step 0 is idle), 1 = wait for clear, 2 = fault
  int entry_path[5] = '{0, 2, 3, 1, 0};
  int exit_path[5]  = '{0, 1, 3, 2, 0};

  bit m_s1a = 0, m_s2a = 0, m_s1b = 0, m_s2b = 0, m_da = 0, m_db = 0;
  bit ra_val = 0, rb_val = 0;
  int ra_len = 0, rb_len = 0;
  int m_mode = 0, m_dir = 0, m_step = 0, m_age = 0;
  bit e_in = 0, e_out = 0, e_fault = 0;

  function automatic int path_pat(input int dir, input int idx);
    if (idx < 0 || idx > 4) return -1;
    return (dir == 1) ? entry_path[idx] : exit_path[idx];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1a = 0; m_s2a = 0; m_s1b = 0; m_s2b = 0; m_da = 0; m_db = 0;
    ra_val = 0; rb_val = 0; ra_len = 0; rb_len = 0;
    m_mode = 0; m_dir = 0; m_step = 0; m_age = 0;
    e_in = 0; e_out = 0; e_fault = 0;
  endtask

  task automatic fsm_step(input bit a, input bit b);
    int p, nmode, ndir, nstep;
    bit pin, pout, changed;
    p = a * 2 + b;
    nmode = m_mode; ndir = m_dir; nstep = m_step;
    pin = 0; pout = 0;
    if (!ent) begin
      nmode = 0; ndir = 0; nstep = 0;
    end else if (m_mode != 0) begin
      if (p == 0) begin nmode = 0; ndir = 0; nstep = 0; end
    end else if (m_step == 0) begin
      if (p == 2) begin ndir = 1; nstep = 1; end
      else if (p == 1) begin ndir = 2; nstep = 1; end
      else if (p == 3) nmode = 1;
    end else if (m_age == TO - 1) begin
      nmode = 2; ndir = 0; nstep = 0;
    end else if (p == path_pat(m_dir, m_step)) begin
      nstep = m_step;
    end else if (p == path_pat(m_dir, m_step + 1)) begin
      nstep = m_step + 1;
      if (nstep == 4) begin
        pin = (m_dir == 1); pout = (m_dir == 2);
        nstep = 0; ndir = 0;
      end
    end else if (p == path_pat(m_dir, m_step - 1)) begin
      nstep = m_step - 1;
      if (nstep == 0) ndir = 0;
    end else begin
      nmode = 1; ndir = 0; nstep = 0;
    end
    changed = (nmode != m_mode) || (ndir != m_dir) || (nstep != m_step);
    m_age   = (!ent || changed) ? 0 : m_age + 1;
    m_mode  = nmode; m_dir = ndir; m_step = nstep;
    e_in    = pin;
    e_out   = pout;
    e_fault = ent && (nmode == 2);
  endtask

  always @(posedge clock) begin
    bit nda, ndb;
    if (!clear) begin
      model_reset();
    end else begin
      if (m_s2a == ra_val) ra_len++; else begin ra_val = m_s2a; ra_len = 1; end
      if (m_s2b == rb_val) rb_len++; else begin rb_val = m_s2b; rb_len = 1; end
      nda = (ra_len >= DEB) ? ra_val : m_da;
      ndb = (rb_len >= DEB) ? rb_val : m_db;
      fsm_step(m_da, m_db);
      m_s2a = m_s1a; m_s1a = beam_a;
      m_s2b = m_s1b; m_s1b = beam_b;
      m_da = nda; m_db = ndb;
    end
  end

  always @(posedge clock) begin
    #1;
    check("in", in, e_in);
    check("out", out, e_out);
    check("fault", fault, e_fault);
    if (in) n_in++;
    if (out) n_out++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pat(input bit [1:0] p, input int hold);
    {beam_a, beam_b} = p;
    cyc(hold);
  endtask

  // Checks the chosen pulse on each of the 5 edges following a release made at this negedge
  task automatic lat_check(input bit want_in);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock);
      #1;
      check(want_in ? "entry_latency" : "exit_latency", want_in ? in : out, (k == 5) ? 1 : 0);
    end
    @(negedge clock);
  endtask

  initial begin
    int i0, o0, hold, r;
    clear = 0; ent = 0;
    cyc(3);
    check("reset_in", in, 0);
    check("reset_out", out, 0);
    check("reset_fault", fault, 0);
    clear = 1; ent = 1;
    cyc(4);

    i0 = n_in; o0 = n_out;
    pat(2'b10, 4); pat(2'b11, 4); pat(2'b01, 4);
    {beam_a, beam_b} = 2'b00;
    lat_check(1'b1);
    cyc(6);
    check("entry_count", n_in - i0, 1);
    check("entry_no_out", n_out - o0, 0);

    i0 = n_in; o0 = n_out;
    pat(2'b01, 4); pat(2'b11, 4); pat(2'b10, 4);
    {beam_a, beam_b} = 2'b00;
    lat_check(1'b0);
    cyc(6);
    check("exit_count", n_out - o0, 1);
    check("exit_no_in", n_in - i0, 0);

    i0 = n_in; o0 = n_out;
    pat(2'b10, 4); pat(2'b11, 4); pat(2'b10, 4); pat(2'b00, 8);
    check("retreat_pulses", (n_in - i0) + (n_out - o0), 0);

    o0 = n_out;
    pat(2'b10, 1); pat(2'b00, 6);
    pat(2'b01, 4); pat(2'b11, 4); pat(2'b10, 4); pat(2'b00, 8);
    check("glitch_then_exit", n_out - o0, 1);

    pat(2'b10, 8);
    check("timeout_early", fault, 0);
    cyc(22);
    check("timeout_fault", fault, 1);
    pat(2'b00, 8);
    check("timeout_release", fault, 0);

    i0 = n_in;
    pat(2'b10, 4); pat(2'b11, 4); pat(2'b01, 4);
    ent = 0; cyc(1);
    pat(2'b00, 10);
    ent = 1; cyc(2);
    check("ent_drop_no_pulse", n_in - i0, 0);

    i0 = n_in;
    pat(2'b10, 4); pat(2'b11, 4); pat(2'b01, 4); pat(2'b00, 4);
    ent = 0; cyc(4);
    ent = 1; cyc(2);
    check("ent_same_cycle_no_pulse", n_in - i0, 0);

    i0 = n_in; o0 = n_out;
    pat(2'b10, 4); pat(2'b11, 6);
    clear = 0;
    #1;
    check("clear_in", in, 0);
    check("clear_out", out, 0);
    check("clear_fault", fault, 0);
    cyc(2);
    clear = 1;
    pat(2'b11, 6); pat(2'b01, 4); pat(2'b00, 8);
    check("clear_discard", (n_in - i0) + (n_out - o0), 0);

    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      hold = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 25) : $urandom_range(1, 6);
      if (r < 4) begin
        if ($urandom_range(0, 1) == 1) begin
          pat(2'b10, hold); pat(2'b11, $urandom_range(1, 6)); pat(2'b01, $urandom_range(1, 6));
        end else begin
          pat(2'b01, hold); pat(2'b11, $urandom_range(1, 6)); pat(2'b10, $urandom_range(1, 6));
        end
        pat(2'b00, $urandom_range(1, 8));
      end else if (r < 8) begin
        pat(2'($urandom_range(0, 3)), hold);
      end else if (r == 8) begin
        ent = 0; cyc($urandom_range(1, 3)); ent = 1;
      end else begin
        clear = 0; cyc($urandom_range(1, 2)); clear = 1;
      end
    end
    pat(2'b00, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
